// File: rtl/imem_responder.sv
// Instruction memory that serves single-cycle fetches to the core and can be
// reprogrammed from a little-endian byte stream while the core is held.
module imem_responder #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AddrWidth-1:0] Inst_mem_address,
  input  logic                 fetch_en,
  output logic [DataWidth-1:0] Instruction,
  output logic                 inst_valid,
  input  logic                 load_start,
  input  logic [AddrWidth:0]   load_len,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic                 core_hold,
  output logic                 load_done,
  output logic [AddrWidth:0]   words_loaded
);

  localparam int BytesPerWord = DataWidth / 8;
  localparam int ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
  localparam int Depth        = 1 << AddrWidth;

  localparam logic [DataWidth-1:0] Nop       = DataWidth'(32'h0000_0013);
  localparam logic [AddrWidth:0]   DepthLen  = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0]   OneWord   = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [ByteCntW-1:0]  LastByte  = ByteCntW'(BytesPerWord - 1);

  typedef enum logic {SERVE, LOAD} state_e;

  state_e                 state_q;
  logic [DataWidth-1:0]   instr_q;
  logic                   valid_q;
  logic                   done_q;
  logic [DataWidth-1:0]   word_q;
  logic [ByteCntW-1:0]    byte_cnt_q;
  logic [AddrWidth-1:0]   wptr_q;
  logic [AddrWidth:0]     words_q;
  logic [AddrWidth:0]     len_q;

  logic [DataWidth-1:0]   mem [Depth];

  logic [DataWidth-1:0]   word_d;
  logic [AddrWidth:0]     words_d;
  logic [AddrWidth:0]     len_clamped;
  logic                   last_byte;
  logic                   word_we;

  // Partial word with the incoming byte merged in at its little-endian slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    word_d = word_q;
    word_d[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
  end

  assign last_byte   = (byte_cnt_q == LastByte);
  assign words_d     = words_q + OneWord;
  assign len_clamped = (load_len > DepthLen) ? DepthLen : load_len;
  assign word_we     = (state_q == LOAD) && rx_valid && last_byte && !reset;

  // NOTE: the memory array carries no reset; program contents survive a reset.
  always_ff @(posedge clock) begin
    if (word_we) begin
      mem[wptr_q] <= word_d;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= SERVE;
      instr_q    <= Nop;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      wptr_q     <= '0;
      words_q    <= '0;
      len_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SERVE: begin
          if (fetch_en) begin
            instr_q <= mem[Inst_mem_address];
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
          if (load_start) begin
            words_q <= '0;
            if (load_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q    <= LOAD;
              byte_cnt_q <= '0;
              wptr_q     <= '0;
              len_q      <= len_clamped;
              instr_q    <= Nop;
              valid_q    <= 1'b0;
            end
          end
        end
        LOAD: begin
          instr_q <= Nop;
          valid_q <= 1'b0;
          if (rx_valid) begin
            word_q <= word_d;
            if (last_byte) begin
              byte_cnt_q <= '0;
              wptr_q     <= wptr_q + AddrWidth'(1);
              words_q    <= words_d;
              // The clamp on len_q guarantees we leave before wptr_q wraps.
              if (words_d == len_q) begin
                state_q <= SERVE;
                done_q  <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + ByteCntW'(1);
            end
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign Instruction  = instr_q;
  assign inst_valid   = valid_q;
  assign load_done    = done_q;
  assign words_loaded = words_q;
  assign core_hold    = (state_q == LOAD);

endmodule
